free_list_alloc: RTL and testbench



---
 rtl/free_list_alloc_pkg.sv | 17 +
 rtl/lsb_psel_gen.sv | 32 +++
 rtl/free_list_alloc.sv | 126 ++++++++++++
 tb/tb_free_list_alloc.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/free_list_alloc_pkg.sv
// -----------------------------------------------------------------------------
// free_list_alloc_pkg
//   Shared system definitions for the entry allocators.
//   Pool sizes and the dispatch width live here so every allocator instance
//   (reservation station, ROB tags, physical registers) agrees on them.
//   This package declares no ports; it only supplies constants.
// -----------------------------------------------------------------------------
package free_list_alloc_pkg;

  // Pool sizes handed to allocator instances as WIDTH.
  localparam int RS_SZ       = 20;
  localparam int PHYS_REG_SZ = 64;

  // Entries dispatch may request per cycle, handed to instances as REQS.
  localparam int DISPATCH_W  = 2;

endpackage

// File: rtl/lsb_psel_gen.sv
// -----------------------------------------------------------------------------
// lsb_psel_gen
//   Multi-slot lowest-set-bit priority selector. Slot 0 receives the lowest
//   set bit of req, slot 1 the next lowest, and so on. A slot with nothing
//   left to select drives zero.
//
//   Ports
//     req  in   WIDTH          request vector
//     gnt  out  REQS x WIDTH   one-hot (or zero) grant per slot
// -----------------------------------------------------------------------------
module lsb_psel_gen #(
  parameter int WIDTH = 20,
  parameter int REQS  = 2
) (
  input  logic [WIDTH-1:0]            req,
  output logic [REQS-1:0][WIDTH-1:0]  gnt
);

  // rem[k] holds the requests still unclaimed when slot k chooses.
  logic [REQS-1:0][WIDTH-1:0] rem;

  assign rem[0] = req;

  for (genvar k = 0; k < REQS; k++) begin : g_slot
    // x & -x isolates the lowest set bit.
    assign gnt[k] = rem[k] & (~rem[k] + WIDTH'(1));
    if (k < REQS-1) begin : g_next
      assign rem[k+1] = rem[k] & ~gnt[k];
    end
  end

endmodule

// File: rtl/free_list_alloc.sv
// -----------------------------------------------------------------------------
// free_list_alloc
//   Owns a WIDTH-entry free bitmap. Grants up to REQS entries per cycle,
//   lowest index first, and retires entries returned by completion logic.
//
//   Ports
//     clock          in   1             rising-edge clock
//     reset          in   1             synchronous active-low reset
//     flush          in   1             return every entry to the pool
//     alloc_num      in   NUM_W         entries requested this cycle
//     free_mask      in   WIDTH         entries released this cycle
//     alloc_valid    out  REQS          slot k granted this cycle
//     alloc_gnt_bus  out  REQS x WIDTH  one-hot entry per slot, zero if invalid
//     alloc_idx      out  REQS x IDX_W  binary index per slot, zero if invalid
//     free_count     out  CNT_W         registered number of free entries
//     none_free      out  1             free_count == 0
//     free_err       out  1             sticky: release of an already-free entry
//
//   Grants are combinational from the registered bitmap (latency 0).
//   Releases become grantable one cycle later; there is no bypass, so an
//   entry is never freed and granted in the same cycle.
// -----------------------------------------------------------------------------
module free_list_alloc
  import free_list_alloc_pkg::*;
#(
  parameter  int WIDTH = RS_SZ,
  parameter  int REQS  = DISPATCH_W,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(WIDTH+1),
  localparam int NUM_W = $clog2(REQS+1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_W-1:0]            alloc_num,
  input  logic [WIDTH-1:0]            free_mask,
  output logic [REQS-1:0]             alloc_valid,
  output logic [REQS-1:0][WIDTH-1:0]  alloc_gnt_bus,
  output logic [REQS-1:0][IDX_W-1:0]  alloc_idx,
  output logic [CNT_W-1:0]            free_count,
  output logic                        none_free,
  output logic                        free_err
);

  logic [WIDTH-1:0]            free_vec;
  logic [WIDTH-1:0]            free_vec_n;
  logic [WIDTH-1:0]            valid_free;
  logic [WIDTH-1:0]            gnt_any;
  logic [REQS-1:0][WIDTH-1:0]  slot_gnt;
  logic [CNT_W-1:0]            free_count_n;
  logic                        err_hit;

  // One-hot to binary; zero input yields index 0.
  function automatic logic [IDX_W-1:0] oh2idx(input logic [WIDTH-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (oh[i]) idx = idx | IDX_W'(i);
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] popcnt_w(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] popcnt_r(input logic [REQS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < REQS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  lsb_psel_gen #(
    .WIDTH (WIDTH),
    .REQS  (REQS)
  ) u_psel (
    .req (free_vec),
    .gnt (slot_gnt)
  );

  // A slot is live only if dispatch asked for it and enough entries are
  // free; comparing against free_count gives the partial-grant behaviour.
  always_comb begin
    alloc_valid   = '0;
    alloc_gnt_bus = '0;
    alloc_idx     = '0;
    gnt_any       = '0;
    for (int k = 0; k < REQS; k++) begin
      alloc_valid[k]   = (int'(alloc_num) > k) && (int'(free_count) > k);
      alloc_gnt_bus[k] = alloc_valid[k] ? slot_gnt[k] : '0;
      alloc_idx[k]     = oh2idx(alloc_gnt_bus[k]);
      gnt_any          = gnt_any | alloc_gnt_bus[k];
    end
  end

  // Only releases of busy entries count; a release of a free entry is an
  // upstream bookkeeping bug and is flagged rather than absorbed.
  assign valid_free = free_mask & ~free_vec;
  assign err_hit    = |(free_mask & free_vec);

  // valid_free and gnt_any are disjoint (busy vs free), so the count update
  // is a plain add/subtract.
  assign free_vec_n   = (free_vec | valid_free) & ~gnt_any;
  assign free_count_n = free_count + popcnt_w(valid_free) - popcnt_r(alloc_valid);

  always_ff @(posedge clock) begin
    if (!reset) begin
      free_vec   <= '1;
      free_count <= CNT_W'(WIDTH);
      free_err   <= 1'b0;
    end else if (flush) begin
      free_vec   <= '1;
      free_count <= CNT_W'(WIDTH);
    end else begin
      free_vec   <= free_vec_n;
      free_count <= free_count_n;
      if (err_hit) free_err <= 1'b1;
    end
  end

  assign none_free = (free_count == '0);

endmodule

// File: tb/tb_free_list_alloc.sv
module tb_free_list_alloc;

  logic              clock;
  logic              reset;
  logic              flush;
  logic [1:0]        alloc_num;
  logic [19:0]       free_mask;
  logic [1:0]        alloc_valid;
  logic [1:0][19:0]  alloc_gnt_bus;
  logic [1:0][4:0]   alloc_idx;
  logic [4:0]        free_count;
  logic              none_free;
  logic              free_err;

  free_list_alloc #(.WIDTH(20), .REQS(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .alloc_num     (alloc_num),
    .free_mask     (free_mask),
    .alloc_valid   (alloc_valid),
    .alloc_gnt_bus (alloc_gnt_bus),
    .alloc_idx     (alloc_idx),
    .free_count    (free_count),
    .none_free     (none_free),
    .free_err      (free_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  ev;
    int          e0;
    int          e1;
    int          ecnt;
    bit          eerr;
    logic [19:0] evec;
    string       nm;
  } exp_t;

  exp_t        q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [19:0] mvec;
  bit          merr;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic int pop20(input logic [19:0] v);
    int c = 0;
    for (int i = 0; i < 20; i++) if (v[i]) c++;
    return c;
  endfunction

  // Reference: walk the bitmap upward, granting up to num free entries.
  function automatic void mgrant(input logic [19:0] v, input int num,
                                 output logic [1:0] ev, output int e0, output int e1);
    int s = 0;
    ev = 2'b00; e0 = 0; e1 = 0;
    for (int i = 0; i < 20; i++) begin
      if (v[i] && s < num) begin
        if (s == 0) begin ev[0] = 1'b1; e0 = i; end
        else        begin ev[1] = 1'b1; e1 = i; end
        s++;
      end
    end
  endfunction

  // Drive one cycle, queue the expected outputs, advance the model.
  task automatic step(input int num, input logic [19:0] mask, input bit fl, input bit rs,
                      input logic [1:0] ev, input int e0, input int e1,
                      input int ecnt, input bit eerr, input string nm);
    exp_t        e;
    logic [1:0]  gv;
    int          g0, g1;
    logic [19:0] gm;
    alloc_num = 2'(num);
    free_mask = mask;
    flush     = fl;
    reset     = rs;
    e.ev = ev; e.e0 = e0; e.e1 = e1; e.ecnt = ecnt; e.eerr = eerr;
    e.evec = mvec; e.nm = nm;
    q.push_back(e);
    if (!rs) begin
      mvec = '1; merr = 1'b0;
    end else if (fl) begin
      mvec = '1;
    end else begin
      if (|(mask & mvec)) merr = 1'b1;
      mgrant(mvec, num, gv, g0, g1);
      gm = '0;
      if (gv[0]) gm[g0] = 1'b1;
      if (gv[1]) gm[g1] = 1'b1;
      mvec = (mvec | (mask & ~mvec)) & ~gm;
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare with the queue.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [19:0] w0, w1;
      e  = q.pop_front();
      w0 = e.ev[0] ? (20'd1 << e.e0) : 20'd0;
      w1 = e.ev[1] ? (20'd1 << e.e1) : 20'd0;
      chk({e.nm, ".valid"}, 64'(alloc_valid), 64'(e.ev));
      chk({e.nm, ".gnt0"},  64'(alloc_gnt_bus[0]), 64'(w0));
      chk({e.nm, ".gnt1"},  64'(alloc_gnt_bus[1]), 64'(w1));
      chk({e.nm, ".idx0"},  64'(alloc_idx[0]), 64'(e.ev[0] ? e.e0 : 0));
      chk({e.nm, ".idx1"},  64'(alloc_idx[1]), 64'(e.ev[1] ? e.e1 : 0));
      chk({e.nm, ".count"}, 64'(free_count), 64'(e.ecnt));
      chk({e.nm, ".none_free"}, 64'(none_free), 64'(e.ecnt == 0));
      chk({e.nm, ".free_err"},  64'(free_err), 64'(e.eerr));
      chk({e.nm, ".free_vec"},  64'(dut.free_vec), 64'(e.evec));
      chk({e.nm, ".cnt_vs_vec"}, 64'(free_count), 64'(pop20(dut.free_vec)));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rv;
    int          r0, r1, rn;
    logic [19:0] rm;
    bit          rf;
    reset = 1'b0; flush = 1'b0; alloc_num = '0; free_mask = '0;
    mvec = '1; merr = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Fill the pool two at a time: pairs (0,1) .. (18,19).
    for (int i = 0; i < 10; i++)
      step(2, 20'h0, 0, 1, 2'b11, 2*i, 2*i+1, 20-2*i, 0, $sformatf("fill%0d", i));
    step(2, 20'h0, 0, 1, 2'b00, 0, 0, 0, 0, "empty");

    // Release while empty: no same-cycle grant, grantable next cycle.
    step(2, 20'h1 << 5, 0, 1, 2'b00, 0, 0, 0, 0, "rel5");
    step(2, 20'h0,      0, 1, 2'b01, 5, 0, 1, 0, "gnt5");

    // Only entry 7 free, two requested: partial grant.
    step(0, 20'h1 << 7, 0, 1, 2'b00, 0, 0, 0, 0, "rel7");
    step(2, 20'h0,      0, 1, 2'b01, 7, 0, 1, 0, "gnt7");
    step(0, 20'h0,      0, 1, 2'b00, 0, 0, 0, 0, "empty2");

    // Release of an already-free entry after reset.
    step(0, 20'h0,      0, 0, 2'b00, 0, 0, 0, 0, "rst1");
    step(0, 20'h1 << 3, 0, 1, 2'b00, 0, 0, 20, 0, "dupfree");
    step(0, 20'h0,      0, 1, 2'b00, 0, 0, 20, 1, "errset");
    step(2, 20'h0,      0, 1, 2'b11, 0, 1, 20, 1, "a01");
    step(2, 20'h0,      0, 1, 2'b11, 2, 3, 18, 1, "a23");
    step(2, 20'h0,      0, 1, 2'b11, 4, 5, 16, 1, "a45");

    // Flush with alloc and release in the same cycle; free_err survives.
    step(2, 20'h1,      1, 1, 2'b11, 6, 7, 14, 1, "flush");
    step(0, 20'h0,      0, 1, 2'b00, 0, 0, 20, 1, "postflush");

    // Same sequence with reset: free_err clears too.
    step(2, 20'h0,      0, 1, 2'b11, 0, 1, 20, 1, "b01");
    step(2, 20'h0,      0, 1, 2'b11, 2, 3, 18, 1, "b23");
    step(2, 20'h0,      0, 1, 2'b11, 4, 5, 16, 1, "b45");
    step(2, 20'h1,      0, 0, 2'b11, 6, 7, 14, 1, "rst2");
    step(0, 20'h0,      0, 1, 2'b00, 0, 0, 20, 0, "postrst");

    // Random traffic against the reference model; releases hit busy bits only.
    for (int i = 0; i < 1000; i++) begin
      rn = $urandom_range(0, 2);
      rm = 20'($urandom & $urandom) & ~mvec;
      rf = ($urandom_range(0, 99) == 0);
      mgrant(mvec, rn, rv, r0, r1);
      step(rn, rm, rf, 1, rv, r0, r1, pop20(mvec), merr, $sformatf("rnd%0d", i));
    end

    @(negedge clock);
    #1;
    chk("drain", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
